// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg : ID->EXE pipeline register with flush, freeze and bubble count.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : kill the entry captured on this edge (becomes a bubble)
//   freeze               : stall; all registered state holds
//   *_in                 : decode control bits / fields / operands to capture
//   *_out                : registered copies of *_in (one cycle latency)
//   valid_out            : entry is a real instruction, not a bubble
//   bubble_cnt           : saturating count of flush edges plus stall edges
//
// Edge priority: rst > flush > freeze > load. All outputs come straight from
// flops, so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module id_stage_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             freeze,
   input  logic             WB_EN_in,
   input  logic             MEM_R_in,
   input  logic             MEM_W_in,
   input  logic             B_in,
   input  logic             S_in,
   input  logic             imm_in,
   input  logic [3:0]       EXE_CMD_in,
   input  logic [3:0]       dest_in,
   input  logic [3:0]       src1_in,
   input  logic [3:0]       src2_in,
   input  logic [31:0]      PC_in,
   input  logic [31:0]      val_rn_in,
   input  logic [31:0]      val_rm_in,
   input  logic [23:0]      signed_imm_in,
   input  logic [11:0]      Shift_Operand_in,
   input  logic             carry_in,
   output logic             WB_EN_out,
   output logic             MEM_R_out,
   output logic             MEM_W_out,
   output logic             B_out,
   output logic             S_out,
   output logic             imm_out,
   output logic [3:0]       EXE_CMD_out,
   output logic [3:0]       dest_out,
   output logic [3:0]       src1_out,
   output logic [3:0]       src2_out,
   output logic [31:0]      PC_out,
   output logic [31:0]      val_rn_out,
   output logic [31:0]      val_rm_out,
   output logic [23:0]      signed_imm_out,
   output logic [11:0]      Shift_Operand_out,
   output logic             carry_out,
   output logic             valid_out,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic        wb_en;
      logic        mem_r;
      logic        mem_w;
      logic        b;
      logic        s;
      logic        imm;
      logic [3:0]  exe_cmd;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [31:0] pc;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic [23:0] signed_imm;
      logic [11:0] shift_op;
      logic        carry;
      logic        valid;
   } entry_t;

   entry_t           entry_q, entry_d, in_e;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   assign in_e = {WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in, imm_in,
                  EXE_CMD_in, dest_in, src1_in, src2_in,
                  PC_in, val_rn_in, val_rm_in, signed_imm_in,
                  Shift_Operand_in, carry_in, 1'b1};

   // Saturate instead of wrapping so a long stall never reads as few bubbles.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      if (flush) begin
         // Whole entry zeroed: control bits, data, sources and valid together,
         // so a bubble can never carry a live B or MEM_W.
         entry_d = '0;
         cnt_d   = cnt_inc;
      end else if (freeze) begin
         cnt_d   = cnt_inc;
      end else begin
         entry_d = in_e;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
         cnt_q   <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign WB_EN_out         = entry_q.wb_en;
   assign MEM_R_out         = entry_q.mem_r;
   assign MEM_W_out         = entry_q.mem_w;
   assign B_out             = entry_q.b;
   assign S_out             = entry_q.s;
   assign imm_out           = entry_q.imm;
   assign EXE_CMD_out       = entry_q.exe_cmd;
   assign dest_out          = entry_q.dest;
   assign src1_out          = entry_q.src1;
   assign src2_out          = entry_q.src2;
   assign PC_out            = entry_q.pc;
   assign val_rn_out        = entry_q.val_rn;
   assign val_rm_out        = entry_q.val_rm;
   assign signed_imm_out    = entry_q.signed_imm;
   assign Shift_Operand_out = entry_q.shift_op;
   assign carry_out         = entry_q.carry;
   assign valid_out         = entry_q.valid;
   assign bubble_cnt        = cnt_q;

endmodule

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have flush  input  1  branch-taken kill; the next captured entry becomes a bubble.
REQ-005 SHALL have freeze  input  1  hazard stall; all registered state holds its value.
REQ-006 SHALL have inputs WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in, imm_in  1 each  decode control bits.
REQ-007 SHALL have inputs EXE_CMD_in 4, dest_in 4, src1_in 4, src2_in 4  decode fields.
REQ-008 SHALL have inputs PC_in 32, val_rn_in 32, val_rm_in 32, signed_imm_in 24, Shift_Operand_in 12, carry_in 1.
REQ-009 SHALL have registered outputs with the same names and widths, suffix _out in place of _in.
REQ-010 SHALL have valid_out  output  1  entry holds a real instruction, not a bubble.
REQ-011 SHALL have bubble_cnt  output  CNT_W  saturating count of bubbles inserted.

Function
REQ-012 SHALL evaluate update priority per edge as: rst, then flush, then freeze, then load.
REQ-013 Load (flush=0, freeze=0): SHALL capture every _in into its _out and set valid_out=1 one cycle later; latency exactly 1 cycle.
REQ-014 Flush=1: SHALL clear WB_EN, MEM_R, MEM_W, B and S to 0, clear valid_out, and clear all data fields to 0 on that edge.
REQ-015 Flush=1 with freeze=1: SHALL apply the flush; a frozen entry never survives a flush.
REQ-016 Freeze=1, flush=0: SHALL hold all _out fields, valid_out and carry_out unchanged, for any number of cycles.
REQ-017 SHALL never produce a state in which B_out=1 or MEM_W_out=1 while valid_out=0.
REQ-018 bubble_cnt SHALL increment by 1 on each edge where flush=1.
REQ-019 bubble_cnt SHALL increment by 1 on each edge where freeze=1 and flush=0, counting stall cycles.
REQ-020 bubble_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 carry_out SHALL be the carry_in captured with the instruction, so EXE uses the flag valid at decode time.
REQ-022 src1_out and src2_out SHALL be registered alongside the data fields for the forwarding unit.
REQ-023 src1_out and src2_out SHALL be zeroed on flush.
REQ-024 SHALL contain no combinational path from any input to any output.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for clk, drive all _out fields, valid_out and bubble_cnt to 0.
REQ-026 While rst=1, flush, freeze and all _in values SHALL be ignored.
REQ-027 On the first clk edge after rst deasserts, SHALL perform a normal load, flush or freeze.
REQ-028 Asserting rst mid-freeze SHALL discard the held entry; the held entry SHALL NOT reappear after rst deasserts.

Verification
REQ-029 Basic load: load PC_in=0x10, EXE_CMD_in=4'b0010, WB_EN_in=1, val_rn_in=0xA5 -> next cycle PC_out=0x10, EXE_CMD_out=2, WB_EN_out=1, val_rn_out=0xA5, valid_out=1.
REQ-030 Freeze hold: load entry A, then freeze=1 for 3 cycles while _in changes to B -> outputs stay A for 3 cycles, bubble_cnt=3, then B appears one cycle after freeze drops.
REQ-031 Flush: flush=1 with MEM_W_in=1, B_in=1 -> next cycle MEM_W_out=0, B_out=0, valid_out=0, all data 0, bubble_cnt +1.
REQ-032 Simultaneous flush and freeze: flush=1 and freeze=1 together over a valid entry -> entry cleared, valid_out=0, bubble_cnt +1 only.
REQ-033 Async reset: assert rst between edges while outputs are nonzero -> all outputs 0 before the next edge.
REQ-034 Async reset during freeze: rst during freeze -> outputs 0; after release with freeze=0, loads the new _in.
REQ-035 Saturation: CNT_W=4, hold flush=1 for 20 cycles -> bubble_cnt reaches 15 and stays at 15.
